tag_stream_generator: RTL and testbench
=======================================

Name: tag_stream_generator

Overview:
- Synthesizable time-tag source for the FPGA-link datapath.
- Samples NUM_CHANNELS asynchronous inputs on the system clock and time-stamps per-channel rising/falling edges against a free-running picosecond counter.
- Buffers the edge events, then emits them as sorted, signed-channel tags on an axis_tag_interface master, up to WORD_WIDTH tags per beat.
- Feeds histogrammers and other tag consumers in hardware loopback and board bring-up, where no external Time Tagger is attached.

Parameters:
NUM_CHANNELS, 16, number of input channels (1..64)
DEPTH, 64, event FIFO entries (power of two, >=4)
CLK_PERIOD_PS, 3200, picosecond increment of the time counter per clk
SYNC_STAGES, 2, synchroniser flops per input (>=2)

Ports:
clk  in  1  system clock (312.5 MHz typical)
rst_n  in  1  asynchronous active-low reset
chx  in  NUM_CHANNELS  asynchronous channel inputs
rise_en  in  NUM_CHANNELS  per-channel rising-edge enable (quasi-static)
fall_en  in  NUM_CHANNELS  per-channel falling-edge enable (quasi-static)
m_time  master  axis_tag_interface  output tag stream; tvalid, tkeep[WORD_WIDTH], tagtime[], channel[], lowest_time_bound; TIME_WIDTH/CHANNEL_WIDTH/WORD_WIDTH are taken from the interface
overflow  out  1  sticky: an edge event was dropped
dropped_count  out  32  saturating count of dropped edge-event cycles

Behaviour:
- Reset: one clock, clk; reset is asynchronous, active-low rst_n. While rst_n=0, all flops clear: time counter=0, FIFO empty, tvalid=0, tkeep=0, tagtime/channel=0, lowest_time_bound=0, overflow=0, dropped_count=0. m_time.rst is driven as ~rst_n and m_time.clk as clk. Reset asserted mid-stream discards all buffered events; a beat in flight is dropped without handshake.
- Time counter: TIME_WIDTH bits, += CLK_PERIOD_PS every cycle, wraps modulo 2^TIME_WIDTH.
- Sampling: chx passes through SYNC_STAGES flops, then a one-flop previous-value register. The first sample after reset is loaded without generating edges.
- Edge vector per cycle: rise = cur&~prev&rise_en; fall = ~cur&prev&fall_en. A cycle with any set bit pushes one FIFO entry {time, rise, fall}; the timestamp is the counter value in the detect cycle.
- Input-to-FIFO latency is SYNC_STAGES+1 cycles.
- FIFO full: if the push would exceed DEPTH, the entry is dropped, overflow is set, and dropped_count increments, saturating at 2^32-1. No other side effect.
- Unpacker FSM, states IDLE, LOAD, EMIT:
  - IDLE→LOAD when the FIFO is non-empty.
  - LOAD pops the head into a pending register, then → EMIT.
  - EMIT presents up to WORD_WIDTH tags from pending, in ascending channel index. For a given channel, rising comes before falling; both cannot occur in one entry.
  - Tag encoding: rising k → channel=k+1; falling k → channel=2^CHANNEL_WIDTH-(k+1). All tags carry the entry's time.
  - Lanes fill from lane 0 upward; tkeep marks the used lanes, and tvalid=|tkeep.
  - When a beat is accepted (tvalid&tready), consumed bits are cleared. If pending becomes empty: → LOAD if the FIFO is non-empty, otherwise → IDLE. Back-to-back beats are required, with no bubble between entries.
- AXI rules: once tvalid rises, the beat (tkeep, tagtime, channel) holds stable until tready. Unused lanes drive 0.
- lowest_time_bound:
  - Updates on accepted beats to the beat's time.
  - In IDLE with an empty FIFO and an empty synchroniser pipeline, it tracks counter-(SYNC_STAGES+1)*CLK_PERIOD_PS.
  - It is monotonic non-decreasing, except across counter wrap.
- Simultaneous push and pop on a full FIFO: the pop takes effect first, so the push succeeds.

Decomposition:
- Package tag_gen_pkg holds: entry struct typedef {time, rise, fall}; unpacker state enum; function encode_channel(idx, is_fall).
- One natural sub-module: tag_gen_event_fifo (synchronous FIFO, DEPTH entries, full/empty, registered read).

Test Plan:
1. Single pulse: rise_en=fall_en='1, pulse chx[3] for 10 cycles starting cycle 100 → two beats: channel 4 with time T, then channel 2^CW-4 with time T+32000; tkeep=0001 on each.
2. Multi-edge: chx[0,1,2,5,7] rise in the same cycle, WORD_WIDTH=4 → beat 1 channels 1,2,3,6 tkeep=1111; beat 2 channel 8 tkeep=0001; identical tagtime on all.
3. Backpressure: hold tready=0 for 20 cycles with 3 queued entries → first beat stable throughout; all 3 delivered in order after release; no loss.
4. Overflow: DEPTH=4, tready=0, toggle chx[0] on 6 consecutive cycles → overflow=1, dropped_count=2, the first 4 entries are delivered intact.
5. Enable masks: rise_en[2]=0, fall_en[2]=1, pulse chx[2] → only the falling tag (2^CW-3) is emitted.
6. Reset mid-operation: pull rst_n low asynchronously between clk edges while a beat is pending → tvalid drops immediately; after release, FIFO is empty, no stale tags, and lowest_time_bound restarts from 0.

Source files
------------

// File: rtl/tag_gen_pkg.sv
// tag_gen_pkg: shared entry format, unpacker states and tag channel encoding
package tag_gen_pkg;
  localparam int MAX_CH = 64;
  localparam int MAX_TW = 64;

  typedef struct packed {
    logic [MAX_TW-1:0] tstamp;
    logic [MAX_CH-1:0] rise;
    logic [MAX_CH-1:0] fall;
  } entry_t;

  typedef logic [1:0] unpack_state_t;
  localparam unpack_state_t ST_IDLE = 2'd0;
  localparam unpack_state_t ST_LOAD = 2'd1;
  localparam unpack_state_t ST_EMIT = 2'd2;

  // rising k -> k+1, falling k -> 2^cw-(k+1); caller truncates to cw bits
  function automatic logic [63:0] encode_channel(input int unsigned idx, input logic is_fall,
                                                 input int unsigned cw);
    logic [64:0] span;
    span = 65'd1 << cw;
    return is_fall ? 64'(span - 65'(idx) - 65'd1) : 64'(idx + 1);
  endfunction
endpackage

// File: rtl/axis_tag_interface.sv
// axis_tag_interface: tag stream with up to WORD_WIDTH tags per beat
interface axis_tag_interface #(
  parameter int TIME_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 32,
  parameter int WORD_WIDTH    = 4
);
  logic clk;
  logic rst;
  logic tvalid;
  logic tready;
  logic [WORD_WIDTH-1:0] tkeep;
  logic [WORD_WIDTH-1:0][TIME_WIDTH-1:0] tagtime;
  logic [WORD_WIDTH-1:0][CHANNEL_WIDTH-1:0] channel;
  logic [TIME_WIDTH-1:0] lowest_time_bound;

  modport master(output clk, rst, tvalid, tkeep, tagtime, channel, lowest_time_bound,
                 input tready);
  modport slave(input clk, rst, tvalid, tkeep, tagtime, channel, lowest_time_bound,
                output tready);
endinterface

// File: rtl/tag_gen_event_fifo.sv
// tag_gen_event_fifo: synchronous edge-event FIFO; a pop frees space for a same-cycle push
module tag_gen_event_fifo
  import tag_gen_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t dout,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);

  entry_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic rd_ok;
  logic wr_ok;

  assign empty = wr_ptr == rd_ptr;
  assign full  = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign rd_ok = pop & ~empty;
  assign wr_ok = push & (~full | rd_ok);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // advance read/write pointers; the extra MSB tells full from empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end

  // event storage, contents only meaningful between the pointers
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/tag_stream_generator.sv
// tag_stream_generator: time-stamps channel edges and streams them as sorted signed-channel tags
module tag_stream_generator
  import tag_gen_pkg::*;
#(
  parameter int NUM_CHANNELS  = 16,
  parameter int DEPTH         = 64,
  parameter int CLK_PERIOD_PS = 3200,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CHANNELS-1:0] chx,
  input  logic [NUM_CHANNELS-1:0] rise_en,
  input  logic [NUM_CHANNELS-1:0] fall_en,
  axis_tag_interface.master       m_time,
  output logic                    overflow,
  output logic [31:0]             dropped_count
);
  localparam int TW = m_time.TIME_WIDTH;
  localparam int CW = m_time.CHANNEL_WIDTH;
  localparam int WW = m_time.WORD_WIDTH;
  localparam logic [TW-1:0] LAG = TW'((SYNC_STAGES + 1) * CLK_PERIOD_PS);

  logic [TW-1:0] tcnt;
  logic [SYNC_STAGES-1:0][NUM_CHANNELS-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld;
  logic [NUM_CHANNELS-1:0] prev;
  logic [NUM_CHANNELS-1:0] cur;
  logic [NUM_CHANNELS-1:0] rise_v;
  logic [NUM_CHANNELS-1:0] fall_v;
  logic primed;
  logic pipe_quiet;
  logic push;
  logic pop;
  logic full;
  logic empty;
  entry_t din;
  entry_t head;
  unpack_state_t state;
  logic [2*MAX_CH-1:0] pend_c;
  logic [2*MAX_CH-1:0] used;
  logic [2*MAX_CH-1:0] rem;
  logic [TW-1:0] pend_t;
  logic [WW-1:0] keep;
  logic [WW-1:0][CW-1:0] chan;
  logic [WW-1:0][TW-1:0] ttime;
  logic tvalid;
  logic acc;
  logic idle_quiet;
  logic [TW-1:0] ltb;

  // candidate tags in emission order: rise k at bit 2k, fall k at bit 2k+1
  function automatic logic [2*MAX_CH-1:0] interleave(input entry_t e);
    logic [2*MAX_CH-1:0] r;
    for (int i = 0; i < MAX_CH; i++) begin
      r[2*i]   = e.rise[i];
      r[2*i+1] = e.fall[i];
    end
    return r;
  endfunction

  assign cur    = sync_q[SYNC_STAGES-1];
  assign rise_v = primed ? cur & ~prev & rise_en : '0;
  assign fall_v = primed ? ~cur & prev & fall_en : '0;
  assign push   = |{rise_v, fall_v};
  assign din    = '{tstamp: 64'(tcnt), rise: 64'(rise_v), fall: 64'(fall_v)};

  // free-running time base and input synchroniser; edges stay masked until prev holds a real sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tcnt   <= '0;
      sync_q <= '0;
      vld    <= '0;
      prev   <= '0;
      primed <= 1'b0;
    end else begin
      tcnt   <= tcnt + TW'(CLK_PERIOD_PS);
      sync_q <= {sync_q[SYNC_STAGES-2:0], chx};
      vld    <= {vld[SYNC_STAGES-2:0], 1'b1};
      prev   <= cur;
      primed <= vld[SYNC_STAGES-1];
    end

  // no edge can be in flight while every synchroniser stage agrees with prev
  always_comb begin
    pipe_quiet = primed;
    for (int i = 0; i < SYNC_STAGES; i++) pipe_quiet = pipe_quiet & (sync_q[i] == prev);
  end

  tag_gen_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  (din),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  // pick the first WW pending tags in channel order and pack them from lane 0
  always_comb begin
    int lane;
    lane  = 0;
    keep  = '0;
    chan  = '0;
    ttime = '0;
    used  = '0;
    for (int i = 0; i < 2*MAX_CH; i++)
      if (state == ST_EMIT && pend_c[i] && lane < WW) begin
        keep[lane] = 1'b1;
        chan[lane] = CW'(encode_channel(unsigned'(i / 2), (i % 2) == 1, CW));
        used[i]    = 1'b1;
        lane       = lane + 1;
      end
    for (int l = 0; l < WW; l++) ttime[l] = keep[l] ? pend_t : '0;
  end

  assign tvalid     = |keep;
  assign acc        = tvalid & m_time.tready;
  assign rem        = pend_c & ~used;
  assign pop        = state == ST_LOAD || (acc && rem == '0 && !empty);
  assign idle_quiet = state == ST_IDLE && empty && pipe_quiet;

  // unpacker: a drained entry is refilled straight from the FIFO head so beats stay back-to-back
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= ST_IDLE;
      pend_c <= '0;
      pend_t <= '0;
    end else if (state == ST_IDLE) begin
      if (!empty) state <= ST_LOAD;
    end else if (state == ST_LOAD) begin
      pend_c <= interleave(head);
      pend_t <= head.tstamp[TW-1:0];
      state  <= ST_EMIT;
    end else if (acc && rem == '0 && !empty) begin
      pend_c <= interleave(head);
      pend_t <= head.tstamp[TW-1:0];
    end else if (acc) begin
      pend_c <= rem;
      if (rem == '0) state <= ST_IDLE;
    end

  // lower bound on future tag times: last delivered time, or counter minus pipeline lag when idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ltb <= '0;
    else if (acc) ltb <= pend_t;
    else if (idle_quiet && tcnt >= LAG && (tcnt - LAG > ltb || tcnt < ltb)) ltb <= tcnt - LAG;

  // sticky overflow and saturating count of dropped events
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      overflow      <= 1'b0;
      dropped_count <= '0;
    end else if (push && full && !pop) begin
      overflow      <= 1'b1;
      dropped_count <= dropped_count == '1 ? dropped_count : dropped_count + 32'd1;
    end

  assign m_time.clk               = clk;
  assign m_time.rst               = ~rst_n;
  assign m_time.tvalid            = tvalid;
  assign m_time.tkeep             = keep;
  assign m_time.tagtime           = ttime;
  assign m_time.channel           = chan;
  assign m_time.lowest_time_bound = ltb;
endmodule

// File: tb/tb_tag_stream_generator.sv
// tb_tag_stream_generator: directed tests of edge tagging, packing, backpressure, overflow and reset
module tb_tag_stream_generator;
  localparam int NC = 8;
  localparam int CP = 3200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NC-1:0] chx = '0;
  logic [NC-1:0] rise_en = '1;
  logic [NC-1:0] fall_en = '1;
  logic overflow;
  logic [31:0] dropped_count;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int k;
  int j;

  typedef struct packed {
    logic [3:0] keep;
    logic [3:0][31:0] ch;
    logic [3:0][63:0] t;
  } beat_t;
  beat_t q[$];

  axis_tag_interface m_if ();

  tag_stream_generator #(
    .NUM_CHANNELS (NC),
    .DEPTH        (4),
    .CLK_PERIOD_PS(CP),
    .SYNC_STAGES  (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .chx          (chx),
    .rise_en      (rise_en),
    .fall_en      (fall_en),
    .m_time       (m_if),
    .overflow     (overflow),
    .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  // record every beat that will be accepted on the next rising edge
  always @(negedge clk)
    if (m_if.tvalid && m_if.tready) begin
      beat_t b;
      b.keep = m_if.tkeep;
      b.ch   = m_if.channel;
      b.t    = m_if.tagtime;
      q.push_back(b);
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [3:0] keep,
                          input logic [31:0] c0, input logic [31:0] c1,
                          input logic [31:0] c2, input logic [31:0] c3, input int tcyc);
    logic [31:0] ce [4];
    ce = '{c0, c1, c2, c3};
    if (idx >= q.size()) return;
    chk($sformatf("%s keep", tag), 64'(q[idx].keep), 64'(keep));
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("%s ch%0d", tag, l), 64'(q[idx].ch[l]), 64'(ce[l]));
      chk($sformatf("%s t%0d", tag, l), q[idx].t[l], keep[l] ? 64'(tcyc * CP) : 64'd0);
    end
  endtask

  initial begin
    m_if.tready = 1'b1;
    #12;
    chk("rst tvalid", 64'(m_if.tvalid), 0);
    chk("rst tkeep", 64'(m_if.tkeep), 0);
    chk("rst ltb", m_if.lowest_time_bound, 0);
    chk("rst overflow", 64'(overflow), 0);
    chk("rst dropped", 64'(dropped_count), 0);
    #5 rst_n = 1'b1;
    tick(30);
    chk("idle ltb", m_if.lowest_time_bound, 64'((cyc - 4) * CP));

    // single pulse on channel 3
    tick(100 - cyc);
    k = cyc;
    chx[3] = 1'b1;
    tick(10);
    chx[3] = 1'b0;
    tick(12);
    chk("pulse beats", 64'(q.size()), 2);
    chk_beat("pulse rise", 0, 4'b0001, 32'd4, 0, 0, 0, k + 2);
    chk_beat("pulse fall", 1, 4'b0001, 32'hFFFF_FFFC, 0, 0, 0, k + 12);
    q.delete();

    // five simultaneous edges split over two beats
    k = cyc;
    chx = 8'hA7;
    tick(12);
    j = cyc;
    chx = '0;
    tick(14);
    chk("multi beats", 64'(q.size()), 4);
    chk_beat("multi r0", 0, 4'b1111, 32'd1, 32'd2, 32'd3, 32'd6, k + 2);
    chk_beat("multi r1", 1, 4'b0001, 32'd8, 0, 0, 0, k + 2);
    chk_beat("multi f0", 2, 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
             32'hFFFF_FFFA, j + 2);
    chk_beat("multi f1", 3, 4'b0001, 32'hFFFF_FFF8, 0, 0, 0, j + 2);
    q.delete();

    // backpressure with three queued entries
    m_if.tready = 1'b0;
    k = cyc;
    chx[1] = 1'b1;
    tick(1);
    chx[4] = 1'b1;
    tick(1);
    chx[6] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (i >= 5) begin
        chk("bp tvalid", 64'(m_if.tvalid), 1);
        chk("bp ch0", 64'(m_if.channel[0]), 2);
        chk("bp keep", 64'(m_if.tkeep), 1);
      end
    end
    chk("bp none taken", 64'(q.size()), 0);
    m_if.tready = 1'b1;
    tick(8);
    chk("bp beats", 64'(q.size()), 3);
    chk_beat("bp b0", 0, 4'b0001, 32'd2, 0, 0, 0, k + 2);
    chk_beat("bp b1", 1, 4'b0001, 32'd5, 0, 0, 0, k + 3);
    chk_beat("bp b2", 2, 4'b0001, 32'd7, 0, 0, 0, k + 4);
    q.delete();
    k = cyc;
    chx = '0;
    tick(10);
    chk("bp fall beats", 64'(q.size()), 1);
    chk_beat("bp fall", 0, 4'b0111, 32'hFFFF_FFFE, 32'hFFFF_FFFB, 32'hFFFF_FFF9, 0, k + 2);
    q.delete();

    // overflow: one entry parked in the unpacker, then six edges into a 4-deep FIFO
    m_if.tready = 1'b0;
    k = cyc;
    chx[1] = 1'b1;
    tick(6);
    j = cyc;
    for (int i = 0; i < 6; i++) begin
      chx[0] = ~chx[0];
      tick(1);
    end
    tick(6);
    chk("ovf flag", 64'(overflow), 1);
    chk("ovf dropped", 64'(dropped_count), 2);
    m_if.tready = 1'b1;
    tick(8);
    chk("ovf beats", 64'(q.size()), 5);
    chk_beat("ovf p", 0, 4'b0001, 32'd2, 0, 0, 0, k + 2);
    chk_beat("ovf e0", 1, 4'b0001, 32'd1, 0, 0, 0, j + 2);
    chk_beat("ovf e1", 2, 4'b0001, 32'hFFFF_FFFF, 0, 0, 0, j + 3);
    chk_beat("ovf e2", 3, 4'b0001, 32'd1, 0, 0, 0, j + 4);
    chk_beat("ovf e3", 4, 4'b0001, 32'hFFFF_FFFF, 0, 0, 0, j + 5);
    chx = '0;
    tick(10);
    chk("ovf sticky", 64'(overflow), 1);
    q.delete();

    // enable mask: only the falling edge of channel 2
    rise_en[2] = 1'b0;
    chx[2] = 1'b1;
    tick(5);
    k = cyc;
    chx[2] = 1'b0;
    tick(12);
    chk("mask beats", 64'(q.size()), 1);
    chk_beat("mask fall", 0, 4'b0001, 32'hFFFF_FFFD, 0, 0, 0, k + 2);
    rise_en = '1;
    q.delete();

    // asynchronous reset while a beat is stalled
    m_if.tready = 1'b0;
    chx[5] = 1'b1;
    tick(8);
    chk("rr pending", 64'(m_if.tvalid), 1);
    chk("rr ch0", 64'(m_if.channel[0]), 6);
    #3 rst_n = 1'b0;
    #1;
    chk("rr tvalid drop", 64'(m_if.tvalid), 0);
    chk("rr tkeep drop", 64'(m_if.tkeep), 0);
    #22 rst_n = 1'b1;
    cyc = 0;
    m_if.tready = 1'b1;
    #1;
    chk("rr ltb zero", m_if.lowest_time_bound, 0);
    chk("rr overflow", 64'(overflow), 0);
    chk("rr dropped", 64'(dropped_count), 0);
    tick(20);
    chk("rr no stale", 64'(q.size()), 0);
    chk("rr ltb track", m_if.lowest_time_bound, 64'((cyc - 4) * CP));
    k = cyc;
    chx[5] = 1'b0;
    tick(10);
    chk("rr beats", 64'(q.size()), 1);
    chk_beat("rr fall", 0, 4'b0001, 32'hFFFF_FFFA, 0, 0, 0, k + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
